// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and the command logic.
// The receiver (master) presents data/data_valid; the consumer (slave) returns data_ack.
interface uart_rx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;

    modport master (
        output data,
        output data_valid,
        input  data_ack
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, idle-high line.
// Oversampled by sample_en; delivers bytes on a level valid/ack handshake,
// drives RTS flow control and flags framing and overrun errors.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      nrst,
    input  logic      rx,
    input  logic      sample_en,
    output logic      rts,
    output logic      framing_err,
    output logic      overrun,
    uart_rx_if.master bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick_cnt, tick_cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          good_stop;
    logic          bad_stop;

    logic          rx_p0;
    logic          rx_s;

    logic [7:0]    data_q;
    logic          data_valid_q;

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;

    // Two-flop synchronizer for the asynchronous serial line (idle-high preset).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // Frame FSM state register with tick/bit counters and the shift register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= 8'hFF;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_cnt_nx;
            bit_idx  <= bit_idx_nx;
            shreg    <= shreg_nx;
        end
    end

    // Next-state logic; advances only on sample_en and decides at mid-bit ticks.
    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_idx_nx  = bit_idx;
        shreg_nx    = shreg;
        good_stop   = 1'b0;
        bad_stop    = 1'b0;
        if (sample_en) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_nx    = S_START;
                        tick_cnt_nx = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_cnt_nx = '0;
                        if (rx_s) begin
                            state_nx = S_IDLE;
                        end else begin
                            state_nx   = S_DATA;
                            bit_idx_nx = '0;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_FULL) begin
                        tick_cnt_nx = '0;
                        shreg_nx    = {rx_s, shreg[7:1]};
                        bit_idx_nx  = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_nx = S_STOP;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == TICK_FULL) begin
                        tick_cnt_nx = '0;
                        if (rx_s) begin
                            good_stop = 1'b1;
                            state_nx  = S_IDLE;
                        end else begin
                            bad_stop = 1'b1;
                            state_nx = S_WAIT_IDLE;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    state_nx    = S_IDLE;
                    tick_cnt_nx = '0;
                end
            endcase
        end
    end

    // Byte delivery, handshake, error pulses and registered RTS.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            rts          <= 1'b1;
            framing_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            framing_err <= bad_stop;
            overrun     <= 1'b0;
            rts         <= ~data_valid_q;
            if (good_stop) begin
                if (!data_valid_q) begin
                    data_q       <= shreg;
                    data_valid_q <= 1'b1;
                end else if (bus.data_ack) begin
                    // Old byte acknowledged this very clk: replace it, valid stays high.
                    data_q <= shreg;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid_q && bus.data_ack) begin
                data_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random bytes,
// compared against a transaction-level model of the receiver's delivery rules.
module tb_uart_rx;

    localparam int OS = 16;

    logic clk;
    logic nrst;
    logic rx;
    logic sample_en;
    logic rts;
    logic framing_err;
    logic overrun;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx          (rx),
        .sample_en   (sample_en),
        .rts         (rts),
        .framing_err (framing_err),
        .overrun     (overrun),
        .bus         (bus.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Event counters observed on the falling edge.
    int fe_cnt     = 0;
    int ov_cnt     = 0;
    int dv_fall    = 0;
    logic dv_prev  = 1'b0;

    // Reference model state.
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    int         exp_fe    = 0;
    int         exp_ov    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nrst) begin
            if (framing_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (dv_prev && !bus.data_valid) dv_fall++;
        end
        dv_prev = bus.data_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, {24'h0, bus.data}, {24'h0, exp_data});
        check({tag, ".valid"}, {31'h0, bus.data_valid}, {31'h0, exp_valid});
        check({tag, ".rts"}, {31'h0, rts}, {31'h0, ~exp_valid});
        check({tag, ".ferr"}, fe_cnt, exp_fe);
        check({tag, ".ovr"}, ov_cnt, exp_ov);
    endtask

    // Serial frame: start, 8 data bits LSB first, one stop bit of the given level.
    // ack_at_stop raises data_ack for the single clk that carries the stop mid-sample.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic ack_at_stop);
        rx = 1'b0;
        repeat (OS) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (OS) tick();
        end
        rx = stop_lvl;
        for (int j = 0; j < OS; j++) begin
            tick();
            if (ack_at_stop && j == 9) bus.data_ack = 1'b1;
            if (j == 10) bus.data_ack = 1'b0;
        end
    endtask

    // Model of a good frame arriving at the handshake.
    task automatic model_good(input logic [7:0] b, input logic ack_coinc);
        if (!exp_valid) begin
            exp_data  = b;
            exp_valid = 1'b1;
        end else if (ack_coinc) begin
            exp_data = b;
        end else begin
            exp_ov++;
        end
    endtask

    task automatic send_good(input logic [7:0] b, input string tag);
        send_frame(b, 1'b1, 1'b0);
        model_good(b, 1'b0);
        check_all(tag);
    endtask

    task automatic do_ack(input string tag);
        repeat ($urandom_range(0, 4)) tick();
        bus.data_ack = 1'b1;
        tick();
        bus.data_ack = 1'b0;
        if (exp_valid) exp_valid = 1'b0;
        check({tag, ".ack_valid"}, {31'h0, bus.data_valid}, 32'h0);
        tick();
        check({tag, ".ack_rts"}, {31'h0, rts}, 32'h1);
    endtask

    initial begin
        int falls_before;
        logic [7:0] rb;

        nrst         = 1'b0;
        rx           = 1'b1;
        sample_en    = 1'b1;
        bus.data_ack = 1'b0;
        repeat (3) tick();
        check_all("reset");
        nrst = 1'b1;
        repeat (5) tick();

        // Basic receive.
        send_good(8'h55, "basic55");
        do_ack("basic55");
        send_good(8'hA3, "basicA3");
        do_ack("basicA3");

        // Start-bit glitch is rejected.
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (20) tick();
        check_all("glitch");
        send_good(8'h3C, "after_glitch");
        do_ack("after_glitch");

        // Framing error followed by a held break.
        send_frame(8'hF0, 1'b0, 1'b0);
        exp_fe++;
        rx = 1'b0;
        repeat (40) tick();
        rx = 1'b1;
        repeat (20) tick();
        check_all("break");
        send_good(8'h12, "after_break");
        do_ack("after_break");

        // Overrun: second byte dropped while the first is unacknowledged.
        send_good(8'h11, "ovr11");
        send_good(8'h22, "ovr22");
        do_ack("ovr");
        send_good(8'h33, "ovr33");
        do_ack("ovr33");

        // Ack coincident with a completed frame.
        send_good(8'h44, "coinc44");
        falls_before = dv_fall;
        send_frame(8'h55, 1'b1, 1'b1);
        model_good(8'h55, 1'b1);
        check_all("coinc55");
        check("coinc.no_fall", dv_fall, falls_before);
        do_ack("coinc55");

        // Reset during bit 4 of a frame.
        send_good(8'h5A, "pre_reset");
        rx = 1'b0;
        repeat (OS) tick();
        for (int i = 0; i < 4; i++) begin
            rx = ~i[0];
            repeat (OS) tick();
        end
        rx = 1'b0;
        repeat (5) tick();
        nrst = 1'b0;
        #1;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        check("rst_mid.data", {24'h0, bus.data}, 32'h0);
        check("rst_mid.valid", {31'h0, bus.data_valid}, 32'h0);
        check("rst_mid.rts", {31'h0, rts}, 32'h1);
        repeat (3) tick();
        rx   = 1'b1;
        nrst = 1'b1;
        repeat (30) tick();
        check_all("post_reset_idle");
        send_good(8'h7E, "post_reset7E");
        do_ack("post_reset7E");

        // Random bytes, some received back to back without ack (overruns).
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            send_good(rb, "random");
            if ($urandom_range(0, 3) != 0) do_ack("random");
        end
        if (exp_valid) do_ack("random_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1, LSB first, line idle high; the receive-side counterpart to the board UART transmitter.
- Samples an oversampled serial input and assembles bytes.
- Presents each byte on a level valid/ack handshake to the command logic.
- Drives an RTS flow-control output to the host and flags framing and overrun errors.

Parameters:
- OVERSAMPLE, 16, sample_en ticks per bit period; even, >= 4. Tick counter width is $clog2(OVERSAMPLE).

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous to clk, idle high
- sample_en  input  1  single-clk pulse at OVERSAMPLE x baud rate, from the shared baud divider
- rts  output  1  high = receiver can accept a byte (host may send)
- data  output  8  received byte; stable while data_valid is high
- data_valid  output  1  byte available; held high until acknowledged
- data_ack  input  1  consumer acknowledge
- framing_err  output  1  one-clk pulse: stop bit sampled low
- overrun  output  1  one-clk pulse: byte completed while data_valid still high

Behaviour:
- Reset (async, nrst low):
  - Outputs: data=8'h00, data_valid=0, rts=1, framing_err=0, overrun=0.
  - FSM goes to IDLE; synchronizer flops and shift register are preset to all-ones.
  - Reset asserted mid-frame abandons the frame; nothing is delivered.
- Input synchronization:
  - rx passes through two flops before use (rx_s); this adds 2 clk of latency.
  - All FSM decisions use rx_s only.
- Timing:
  - The FSM advances only on clk edges where sample_en=1.
  - tick_cnt counts sample_en pulses within a state.
- State IDLE:
  - On sample_en with rx_s=0: go to START, tick_cnt=0.
- State START:
  - Count ticks. At tick_cnt == OVERSAMPLE/2-1 (mid start bit):
    - rx_s=1: glitch; return to IDLE, no flags.
    - rx_s=0: go to DATA, tick_cnt=0, bit_idx=0.
- State DATA:
  - At tick_cnt == OVERSAMPLE-1 (mid bit): shift rx_s into shift-register MSB, shifting right (LSB-first reception); tick_cnt=0; bit_idx++.
  - After the 8th bit, go to STOP.
- State STOP:
  - At tick_cnt == OVERSAMPLE-1:
    - rx_s=1: frame good; perform the delivery step below, then go to IDLE.
    - rx_s=0: pulse framing_err for 1 clk, discard the byte, go to WAIT_IDLE.
- State WAIT_IDLE:
  - Stay until a sample_en with rx_s=1, then go to IDLE. A break condition therefore yields exactly one framing_err.
- Delivery, on the good-stop clk edge:
  - data_valid=0: load data, set data_valid=1 on the next clk.
  - data_valid=1 and data_ack=0: pulse overrun for 1 clk; data and data_valid unchanged (the new byte is dropped).
  - data_valid=1 and data_ack=1 in the same clk: ack the old byte, load the new byte, data_valid stays 1, no overrun.
- Handshake:
  - data_ack is sampled on every clk, independent of sample_en.
  - data_valid=1 and data_ack=1 (with no delivery) clears data_valid on the next clk.
  - data_ack while data_valid=0 is ignored.
- rts:
  - Registered, rts = ~data_valid.
  - Falls the clk after data_valid rises; rises the clk after data_valid clears.
- End-to-end latency: data_valid rises 1 clk after the clk that carries the stop-bit mid-sample tick.
- A new start edge may be detected on the first sample_en after returning to IDLE; back-to-back frames with one stop bit must be received.

Test Plan:
- Basic receive:
  - Stimulus: OVERSAMPLE=16, sample_en tied high; send 0x55 then 0xA3, acking each within 5 clk.
  - Required: data=0x55 then 0xA3; data_valid high until ack; rts low while valid; no flags.
- Start glitch:
  - Stimulus: drive rx low for 4 ticks, then high.
  - Required: FSM returns to IDLE; data_valid, framing_err and overrun stay 0. A following 0x3C frame is received correctly.
- Framing error:
  - Stimulus: send 0xF0 with the stop bit low; hold rx low for 40 ticks; release; then send 0x12.
  - Required: exactly one framing_err pulse; no data_valid for 0xF0; then data=0x12, valid.
- Overrun:
  - Stimulus: send 0x11, no ack; send 0x22.
  - Required: overrun pulses once at 0x22's stop sample; data stays 0x11.
  - Stimulus: ack, then send 0x33.
  - Required: data=0x33.
- Ack coincident with completion:
  - Stimulus: assert data_ack for 0x44 on the same clk as 0x55's good-stop sample.
  - Required: data=0x55, data_valid stays 1 throughout, no overrun.
- Reset mid-frame:
  - Stimulus: pull nrst low during bit 4 of a frame.
  - Required: outputs immediately return to data=0, valid=0, rts=1. After release, an idle line followed by 0x7E gives data=0x7E.
